// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word fetches, buffers returned instructions
// with their PC in an in-order FIFO and handles decoder redirects.

module fetch_unit_checker #(
    parameter int unsigned CNT_W      = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic             clk_i,
    input logic             rst_i,
    input logic             push_i,
    input logic             rvalid_i,
    input logic [CNT_W-1:0] occ_i,
    input logic [CNT_W-1:0] out_cnt_i
);
    // Catch credit violations: FIFO overflow or a response nobody asked for
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push_i && (occ_i == CNT_W'(FIFO_DEPTH))))
                else $error("fetch_unit: push into full instruction FIFO");
            assert (!(rvalid_i && (out_cnt_i == {CNT_W{1'b0}})))
                else $error("fetch_unit: response with no outstanding request");
        end
    end
endmodule

module fetch_unit #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned           FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    input  logic                  pc_sel_i,
    input  logic [DATA_WIDTH-1:0] branch_target_i,
    input  logic                  stall_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] pc_o
);
    localparam int unsigned           PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned           CNT_W     = PTR_W + 1;
    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);
    localparam logic [DATA_WIDTH-1:0] PC_STEP   = DATA_WIDTH'(32'd4);
    localparam logic [CNT_W:0]        CREDIT_LIM = (CNT_W+1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] fetch_pc_r, fetch_pc_nxt_s;
    logic [CNT_W-1:0]      out_cnt_r, out_cnt_nxt_s;
    logic [CNT_W-1:0]      drop_cnt_r, drop_cnt_nxt_s;
    logic [CNT_W-1:0]      occ_r, occ_nxt_s;
    logic [PTR_W-1:0]      wr_ptr_r, wr_ptr_nxt_s;
    logic [PTR_W-1:0]      rd_ptr_r, rd_ptr_nxt_s;
    logic [DATA_WIDTH-1:0] pc_mem_r    [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] instr_mem_r [FIFO_DEPTH];

    logic                  req_s, grant_s, push_s, pop_s, valid_s;
    logic [CNT_W:0]        credit_s;
    logic [CNT_W-1:0]      live_cnt_s;
    logic [DATA_WIDTH-1:0] target_s, resp_pc_s;

    // Handshake qualifiers; credit counts dropped responses too, keeping it conservative
    always_comb begin
        credit_s   = {1'b0, occ_r} + {1'b0, out_cnt_r};
        req_s      = !rst_i && !pc_sel_i && (credit_s < CREDIT_LIM);
        grant_s    = req_s && imem_gnt_i;
        valid_s    = (occ_r != {CNT_W{1'b0}});
        push_s     = imem_rvalid_i && !pc_sel_i && (drop_cnt_r == {CNT_W{1'b0}});
        pop_s      = valid_s && !stall_i && !pc_sel_i;
        target_s   = branch_target_i & {{(DATA_WIDTH-2){1'b1}}, 2'b00};
        // Oldest live request sits (live outstanding) words behind fetch_pc
        live_cnt_s = out_cnt_r - drop_cnt_r;
        resp_pc_s  = fetch_pc_r - DATA_WIDTH'({live_cnt_s, 2'b00});
    end

    // Next-state logic; a redirect overrides every other update in its cycle
    always_comb begin
        fetch_pc_nxt_s = fetch_pc_r;
        out_cnt_nxt_s  = out_cnt_r;
        drop_cnt_nxt_s = drop_cnt_r;
        occ_nxt_s      = occ_r;
        wr_ptr_nxt_s   = wr_ptr_r;
        rd_ptr_nxt_s   = rd_ptr_r;
        if (pc_sel_i) begin
            fetch_pc_nxt_s = target_s;
            out_cnt_nxt_s  = out_cnt_r - CNT_W'(imem_rvalid_i);
            drop_cnt_nxt_s = out_cnt_r - CNT_W'(imem_rvalid_i);
            occ_nxt_s      = {CNT_W{1'b0}};
            wr_ptr_nxt_s   = {PTR_W{1'b0}};
            rd_ptr_nxt_s   = {PTR_W{1'b0}};
        end else begin
            if (grant_s) begin
                fetch_pc_nxt_s = fetch_pc_r + PC_STEP;
            end else begin
                fetch_pc_nxt_s = fetch_pc_r;
            end
            out_cnt_nxt_s = out_cnt_r + CNT_W'(grant_s) - CNT_W'(imem_rvalid_i);
            if (imem_rvalid_i && (drop_cnt_r != {CNT_W{1'b0}})) begin
                drop_cnt_nxt_s = drop_cnt_r - CNT_W'(1'b1);
            end else begin
                drop_cnt_nxt_s = drop_cnt_r;
            end
            occ_nxt_s = occ_r + CNT_W'(push_s) - CNT_W'(pop_s);
            if (push_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1'b1);
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1'b1);
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc_r <= RESET_PC;
            out_cnt_r  <= {CNT_W{1'b0}};
            drop_cnt_r <= {CNT_W{1'b0}};
            occ_r      <= {CNT_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
        end else begin
            fetch_pc_r <= fetch_pc_nxt_s;
            out_cnt_r  <= out_cnt_nxt_s;
            drop_cnt_r <= drop_cnt_nxt_s;
            occ_r      <= occ_nxt_s;
            wr_ptr_r   <= wr_ptr_nxt_s;
            rd_ptr_r   <= rd_ptr_nxt_s;
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                pc_mem_r[i]    <= {DATA_WIDTH{1'b0}};
                instr_mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (push_s) begin
            pc_mem_r[wr_ptr_r]    <= resp_pc_s;
            instr_mem_r[wr_ptr_r] <= imem_rdata_i;
        end
    end

    // Head of FIFO presented to the decoder, NOP bubble when empty
    always_comb begin
        if (valid_s) begin
            instr_o = instr_mem_r[rd_ptr_r];
            pc_o    = pc_mem_r[rd_ptr_r];
        end else begin
            instr_o = NOP_INSTR;
            pc_o    = {DATA_WIDTH{1'b0}};
        end
    end

    assign imem_req_o  = req_s;
    assign imem_addr_o = fetch_pc_r;
    assign valid_o     = valid_s;

    fetch_unit_checker #(
        .CNT_W      (CNT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_checker (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (push_s),
        .rvalid_i  (imem_rvalid_i),
        .occ_i     (occ_r),
        .out_cnt_i (out_cnt_r)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with configurable
// latency and grant pattern; instruction word returned is ~address.

module tb_fetch_unit;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        pc_sel_i;
    logic [31:0] branch_target_i;
    logic        stall_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mem_req_t;

    mem_req_t    mem_q[$];
    int unsigned cyc = 0;
    int unsigned lat = 1;
    bit          rand_gnt = 1'b0;
    logic        gnt_level = 1'b1;
    logic        hs_s;
    logic [31:0] hs_addr;

    fetch_unit #(
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0000_0100),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_gnt_i      (imem_gnt_i),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .pc_sel_i        (pc_sel_i),
        .branch_target_i (branch_target_i),
        .stall_i         (stall_i),
        .valid_o         (valid_o),
        .instr_o         (instr_o),
        .pc_o            (pc_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory model: sample handshake late in the cycle, respond after the edge
    always @(negedge clk_i) begin
        #4;
        hs_s    = imem_req_o && imem_gnt_i;
        hs_addr = imem_addr_o;
        @(posedge clk_i);
        #1;
        if (rst_i) mem_q.delete();
        else if (hs_s) mem_q.push_back('{addr: hs_addr, due: cyc + lat});
        cyc++;
        imem_gnt_i = rand_gnt ? 1'($urandom_range(0, 1)) : gnt_level;
        if (!rst_i && mem_q.size() > 0 && mem_q[0].due == cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = ~mem_q[0].addr;
            void'(mem_q.pop_front());
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'h0;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic hold_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        logic        saw_valid;
        logic        prev_stall_req;
        logic [31:0] prev_addr;
        logic [31:0] exp_pc;
        int          n_instr;

        rst_i = 1'b1; pc_sel_i = 1'b0; branch_target_i = 32'h0; stall_i = 1'b0;
        imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
        @(negedge clk_i);
        #1;
        check("rst_req",   imem_req_o,  32'd0);
        check("rst_valid", valid_o,     32'd0);
        check("rst_instr", instr_o,     32'h0000_0013);
        check("rst_pc",    pc_o,        32'h0);
        check("rst_addr",  imem_addr_o, 32'h0000_0100);

        // Cold start, 1-cycle memory, always granting
        hold_reset();
        #1;
        check("cold_req",  imem_req_o,  32'd1);
        check("cold_addr", imem_addr_o, 32'h0000_0100);
        tick();
        check("cold_valid_c1", valid_o, 32'd0);
        tick();
        check("cold_valid_c2", valid_o, 32'd1);
        check("cold_pc0",    pc_o,    32'h0000_0100);
        check("cold_instr0", instr_o, 32'hFFFF_FEFF);
        tick(); check("cold_pc1", pc_o, 32'h0000_0104); check("cold_instr1", instr_o, 32'hFFFF_FEFB);
        tick(); check("cold_pc2", pc_o, 32'h0000_0108); check("cold_instr2", instr_o, 32'hFFFF_FEF7);
        tick(); check("cold_pc3", pc_o, 32'h0000_010C); check("cold_instr3", instr_o, 32'hFFFF_FEF3);

        // Stall from the start: FIFO fills, requests stop, head holds
        stall_i = 1'b1;
        hold_reset();
        for (int i = 0; i < 8; i++) tick();
        check("stall_req",   imem_req_o,  32'd0);
        check("stall_addr",  imem_addr_o, 32'h0000_0110);
        check("stall_valid", valid_o,     32'd1);
        check("stall_pc",    pc_o,        32'h0000_0100);
        stall_i = 1'b0;
        tick(); check("drain_pc1", pc_o, 32'h0000_0104);
        tick(); check("drain_pc2", pc_o, 32'h0000_0108);
        tick(); check("drain_pc3", pc_o, 32'h0000_010C);
        tick(); check("drain_pc4", pc_o, 32'h0000_0110);
        check("drain_valid", valid_o, 32'd1);

        // Redirect with three requests in flight, 4-cycle memory
        lat = 4;
        hold_reset();
        tick(); tick(); tick();
        check("rdr_addr_before", imem_addr_o, 32'h0000_010C);
        check("rdr_valid_before", valid_o, 32'd0);
        pc_sel_i = 1'b1; branch_target_i = 32'h0000_2002;
        #1;
        check("rdr_req_blocked", imem_req_o, 32'd0);
        tick();
        pc_sel_i = 1'b0;
        #1;
        check("rdr_valid_r1", valid_o,     32'd0);
        check("rdr_req_r1",   imem_req_o,  32'd1);
        check("rdr_addr_r1",  imem_addr_o, 32'h0000_2000);
        saw_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            saw_valid = saw_valid | valid_o;
        end
        check("rdr_no_stale", saw_valid, 32'd0);
        tick();
        check("rdr_valid",  valid_o, 32'd1);
        check("rdr_pc0",    pc_o,    32'h0000_2000);
        check("rdr_instr0", instr_o, 32'hFFFF_DFFF);
        tick();
        check("rdr_pc1", pc_o, 32'h0000_2004);

        // Redirect coincident with a response while the FIFO is near full
        lat = 1;
        stall_i = 1'b1;
        hold_reset();
        tick(); tick(); tick(); tick();
        check("coin_req_full", imem_req_o, 32'd0);
        check("coin_head",     pc_o,       32'h0000_0100);
        pc_sel_i = 1'b1; branch_target_i = 32'h0000_3000; stall_i = 1'b0;
        tick();
        pc_sel_i = 1'b0;
        #1;
        check("coin_valid_r1", valid_o,     32'd0);
        check("coin_addr_r1",  imem_addr_o, 32'h0000_3000);
        tick();
        check("coin_valid_r2", valid_o, 32'd0);
        tick();
        check("coin_valid_r3", valid_o, 32'd1);
        check("coin_pc",       pc_o,    32'h0000_3000);
        check("coin_instr",    instr_o, 32'hFFFF_CFFF);

        // Random grant backpressure: address holds while stalled, PCs strictly +4
        rand_gnt = 1'b1;
        hold_reset();
        prev_stall_req = 1'b0; prev_addr = 32'h0; exp_pc = 32'h0000_0100; n_instr = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (prev_stall_req) check("bp_addr_hold", imem_addr_o, prev_addr);
            if (valid_o) begin
                check("bp_pc",    pc_o,    exp_pc);
                check("bp_instr", instr_o, ~exp_pc);
                exp_pc = exp_pc + 32'd4;
                n_instr++;
            end
            prev_stall_req = imem_req_o && !imem_gnt_i;
            prev_addr      = imem_addr_o;
        end
        check("bp_progress", 32'(n_instr >= 10), 32'd1);
        rand_gnt = 1'b0;
        tick();

        // Address wrap via redirect, then asynchronous reset mid-stream
        pc_sel_i = 1'b1; branch_target_i = 32'hFFFF_FFF8;
        tick();
        pc_sel_i = 1'b0;
        tick();
        tick();
        check("wrap_pc0",    pc_o,    32'hFFFF_FFF8);
        check("wrap_instr0", instr_o, 32'h0000_0007);
        tick();
        check("wrap_pc1",    pc_o,    32'hFFFF_FFFC);
        check("wrap_instr1", instr_o, 32'h0000_0003);
        tick();
        check("wrap_pc2",    pc_o,    32'h0000_0000);
        check("wrap_instr2", instr_o, 32'hFFFF_FFFF);
        rst_i = 1'b1;
        #1;
        check("mid_rst_valid", valid_o,    32'd0);
        check("mid_rst_instr", instr_o,    32'h0000_0013);
        check("mid_rst_pc",    pc_o,       32'h0);
        check("mid_rst_req",   imem_req_o, 32'd0);
        tick();
        rst_i = 1'b0;
        tick();
        tick();
        check("restart_valid", valid_o, 32'd1);
        check("restart_pc",    pc_o,    32'h0000_0100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
